// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus shift-add multiply and
// restoring divide/modulo, with a ready/done handshake, abort and accumulator chaining.
module alu_seq #(
    parameter int W  = 16,
    parameter int SH = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   op_code,
    input  logic [W-1:0] val,
    input  logic [W-1:0] reg0,
    input  logic         move,
    input  logic         store,
    input  logic         abort,
    output logic         ALU_ready,
    output logic         ALU_done,
    output logic [3:0]   ALU_flags,
    output logic [W-1:0] rez,
    output logic [W-1:0] rez_hi
);
    localparam logic [2:0] S_IDLE = 3'd0, S_EXEC = 3'd1, S_MULT = 3'd2,
                           S_DIVD = 3'd3, S_DONE = 3'd4;

    localparam logic [5:0] OP_ADD = 6'b001010, OP_SUB = 6'b001011, OP_LSR = 6'b001100,
                           OP_LSL = 6'b001101, OP_RSR = 6'b001110, OP_RSL = 6'b001111,
                           OP_AND = 6'b010100, OP_OR  = 6'b010101, OP_XOR = 6'b010110,
                           OP_NOT = 6'b010111, OP_CMP = 6'b011000, OP_TST = 6'b011001,
                           OP_INC = 6'b011010, OP_DEC = 6'b011011, OP_MUL = 6'b011100,
                           OP_DIV = 6'b011101, OP_MOD = 6'b011110;

    localparam int          CW   = SH + 1;
    localparam logic [SH:0] W_SH = (SH+1)'(W);

    logic [2:0]    state_reg;
    logic [5:0]    op_reg;
    logic [W-1:0]  a_reg, b_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  hi_reg, lo_reg;   // MUL: product halves; DIV: remainder / quotient

    logic [W-1:0]  arith_b;
    logic [W:0]    add_ext, sub_ext, lsr_ext, lsl_ext;
    logic [W-1:0]  rot_r, rot_l;
    logic [SH-1:0] sh_amt;
    logic [SH:0]   rot_back;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W+1:0]  div_diff;
    logic          div_borrow;

    logic [W-1:0]  alu_r;
    logic          alu_c, alu_v, alu_valid, alu_wr;

    assign ALU_ready = (state_reg == S_IDLE);

    assign arith_b  = (op_reg == OP_INC || op_reg == OP_DEC) ? W'(1) : b_reg;
    assign add_ext  = {1'b0, a_reg} + {1'b0, arith_b};
    assign sub_ext  = {1'b0, a_reg} - {1'b0, arith_b};
    assign sh_amt   = b_reg[SH-1:0];
    // Extra bit on the shifted-out side captures the last bit lost (0 for a zero shift).
    assign lsr_ext  = {a_reg, 1'b0} >> sh_amt;
    assign lsl_ext  = {1'b0, a_reg} << sh_amt;
    assign rot_back = W_SH - {1'b0, sh_amt};
    assign rot_r    = (a_reg >> sh_amt) | (a_reg << rot_back);
    assign rot_l    = (a_reg << sh_amt) | (a_reg >> rot_back);

    assign mul_sum    = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    assign div_shift  = {hi_reg, lo_reg[W-1]};
    assign div_diff   = {1'b0, div_shift} - {2'b00, b_reg};
    assign div_borrow = div_diff[W+1];

    always_comb begin
        alu_r     = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_valid = 1'b1;
        alu_wr    = 1'b1;
        case (op_reg)
            OP_ADD, OP_INC: begin
                alu_r = add_ext[W-1:0];
                alu_c = add_ext[W];
                alu_v = (a_reg[W-1] == arith_b[W-1]) && (add_ext[W-1] != a_reg[W-1]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                alu_r  = sub_ext[W-1:0];
                alu_c  = sub_ext[W];
                alu_v  = (a_reg[W-1] != arith_b[W-1]) && (sub_ext[W-1] != a_reg[W-1]);
                alu_wr = (op_reg != OP_CMP);
            end
            OP_LSR: begin
                alu_r = lsr_ext[W:1];
                alu_c = lsr_ext[0];
            end
            OP_LSL: begin
                alu_r = lsl_ext[W-1:0];
                alu_c = lsl_ext[W];
            end
            OP_RSR: begin
                alu_r = rot_r;
                alu_c = (sh_amt != '0) && rot_r[W-1];
            end
            OP_RSL: begin
                alu_r = rot_l;
                alu_c = (sh_amt != '0) && rot_l[0];
            end
            OP_AND: alu_r = a_reg & b_reg;
            OP_OR:  alu_r = a_reg | b_reg;
            OP_XOR: alu_r = a_reg ^ b_reg;
            OP_NOT: alu_r = ~a_reg;
            OP_TST: begin
                alu_r  = a_reg & b_reg;
                alu_wr = 1'b0;
            end
            default: begin
                alu_valid = 1'b0;
                alu_wr    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            ALU_done  <= 1'b0;
            ALU_flags <= '0;
            rez       <= '0;
            rez_hi    <= '0;
        end else begin
            ALU_done <= 1'b0;
            case (state_reg)
                S_IDLE: if (move) begin
                    op_reg  <= op_code;
                    a_reg   <= store ? rez : reg0;
                    b_reg   <= val;
                    cnt_reg <= '0;
                    hi_reg  <= '0;
                    if (op_code == OP_MUL) begin
                        lo_reg    <= val;
                        state_reg <= S_MULT;
                    end else if (op_code == OP_DIV || op_code == OP_MOD) begin
                        lo_reg    <= store ? rez : reg0;
                        state_reg <= S_DIVD;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: state_reg <= S_DONE;
                S_MULT: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                    end else if (cnt_reg == CW'(W)) begin
                        state_reg <= S_DONE;
                    end else begin
                        hi_reg  <= mul_sum[W:1];
                        lo_reg  <= {mul_sum[0], lo_reg[W-1:1]};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DIVD: begin
                    if (abort) begin
                        state_reg <= S_IDLE;
                    end else if (cnt_reg == CW'(W)) begin
                        state_reg <= S_DONE;
                    end else begin
                        hi_reg  <= div_borrow ? div_shift[W-1:0] : div_diff[W-1:0];
                        lo_reg  <= {lo_reg[W-2:0], ~div_borrow};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    ALU_done  <= 1'b1;
                    if (op_reg == OP_MUL) begin
                        rez       <= lo_reg;
                        rez_hi    <= hi_reg;
                        ALU_flags <= {hi_reg != '0, hi_reg != '0, lo_reg[W-1], lo_reg == '0};
                    end else if (op_reg == OP_DIV) begin
                        rez       <= lo_reg;
                        rez_hi    <= hi_reg;
                        ALU_flags <= {b_reg == '0, 1'b0, lo_reg[W-1], lo_reg == '0};
                    end else if (op_reg == OP_MOD) begin
                        rez       <= hi_reg;
                        rez_hi    <= lo_reg;
                        ALU_flags <= {b_reg == '0, 1'b0, hi_reg[W-1], hi_reg == '0};
                    end else if (alu_valid) begin
                        ALU_flags <= {alu_v, alu_c, alu_r[W-1], alu_r == '0};
                        if (alu_wr) begin
                            rez <= alu_r;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=16): vector table through a scoreboard queue, plus
// hand-written reset, abort and busy-move sequences.
module tb_alu_seq;
    localparam int W = 16;

    localparam logic [5:0] OP_ADD = 6'b001010, OP_SUB = 6'b001011, OP_LSR = 6'b001100,
                           OP_LSL = 6'b001101, OP_RSR = 6'b001110, OP_RSL = 6'b001111,
                           OP_AND = 6'b010100, OP_OR  = 6'b010101, OP_XOR = 6'b010110,
                           OP_NOT = 6'b010111, OP_CMP = 6'b011000, OP_TST = 6'b011001,
                           OP_INC = 6'b011010, OP_DEC = 6'b011011, OP_MUL = 6'b011100,
                           OP_DIV = 6'b011101, OP_MOD = 6'b011110, OP_NOP = 6'b000000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   op_code = '0;
    logic [W-1:0] val = '0;
    logic [W-1:0] reg0 = '0;
    logic         move = 1'b0;
    logic         store = 1'b0;
    logic         abort = 1'b0;
    logic         ALU_ready, ALU_done;
    logic [3:0]   ALU_flags;
    logic [W-1:0] rez, rez_hi;

    alu_seq #(.W(W)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .val(val), .reg0(reg0),
        .move(move), .store(store), .abort(abort), .ALU_ready(ALU_ready),
        .ALU_done(ALU_done), .ALU_flags(ALU_flags), .rez(rez), .rez_hi(rez_hi)
    );

    always #5 clk = ~clk;

    // Flags are {V,C,N,Z}
    typedef struct {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        st;
        logic        ab;
        logic [15:0] e_rez;
        logic [15:0] e_hi;
        logic [3:0]  e_fl;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] rez;
        logic [15:0] hi;
        logic [3:0]  fl;
        int          lat;
        int          id;
    } exp_t;

    localparam int NV = 26;
    vec_t vecs[NV];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (ALU_done) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic st, input logic ab);
        chk("ready_before_issue", 32'(ALU_ready), 32'd1);
        op_code = op;
        reg0    = a;
        val     = b;
        store   = st;
        abort   = ab;
        move    = 1'b1;
        @(negedge clk);
        move  = 1'b0;
        store = 1'b0;
        abort = 1'b0;
        chk("ready_drop", 32'(ALU_ready), 32'd0);
    endtask

    task automatic wait_done(input int start);
        int   j;
        exp_t e;
        j = start;
        while (!ALU_done && j < 100) begin
            @(negedge clk);
            j++;
        end
        e = sb.pop_front();
        if (!ALU_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout txn %0d: no ALU_done within %0d cycles", e.id, j);
        end else begin
            chk($sformatf("rez[%0d]", e.id), 32'(rez), 32'(e.rez));
            chk($sformatf("rez_hi[%0d]", e.id), 32'(rez_hi), 32'(e.hi));
            chk($sformatf("flags[%0d]", e.id), 32'(ALU_flags), 32'(e.fl));
            chk($sformatf("latency[%0d]", e.id), 32'(j), 32'(e.lat));
            $display("txn %0d: rez=%h rez_hi=%h flags=%b latency=%0d", e.id, rez, rez_hi,
                     ALU_flags, j);
        end
        @(negedge clk);
        chk($sformatf("done_pulse_width[%0d]", e.id), 32'(ALU_done), 32'd0);
        chk($sformatf("ready_after[%0d]", e.id), 32'(ALU_ready), 32'd1);
    endtask

    initial begin
        int d0;
        exp_t e;

        vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h0000, 4'b1010, 2};
        vecs[1]  = '{OP_SUB, 16'h0002, 16'h0003, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 4'b0110, 2};
        vecs[2]  = '{OP_MUL, 16'h1234, 16'h0100, 1'b0, 1'b0, 16'h3400, 16'h0012, 4'b1100, 18};
        vecs[3]  = '{OP_DIV, 16'd100,  16'd7,    1'b0, 1'b0, 16'd14,   16'd2,    4'b0000, 18};
        vecs[4]  = '{OP_DIV, 16'd5,    16'd0,    1'b0, 1'b0, 16'hFFFF, 16'd5,    4'b1010, 18};
        vecs[5]  = '{OP_MOD, 16'd100,  16'd7,    1'b0, 1'b0, 16'd2,    16'd14,   4'b0000, 18};
        vecs[6]  = '{OP_ADD, 16'd3,    16'd4,    1'b0, 1'b1, 16'd7,    16'd14,   4'b0000, 2};
        vecs[7]  = '{OP_ADD, 16'h1234, 16'd10,   1'b1, 1'b0, 16'd17,   16'd14,   4'b0000, 2};
        vecs[8]  = '{OP_CMP, 16'h000C, 16'h0004, 1'b0, 1'b0, 16'd17,   16'd14,   4'b0000, 2};
        vecs[9]  = '{OP_CMP, 16'h0004, 16'h000C, 1'b0, 1'b0, 16'd17,   16'd14,   4'b0110, 2};
        vecs[10] = '{OP_RSR, 16'h000C, 16'd2,    1'b0, 1'b0, 16'h0003, 16'd14,   4'b0000, 2};
        vecs[11] = '{OP_RSL, 16'h8001, 16'd1,    1'b0, 1'b0, 16'h0003, 16'd14,   4'b0100, 2};
        vecs[12] = '{OP_LSL, 16'h000C, 16'd0,    1'b0, 1'b0, 16'h000C, 16'd14,   4'b0000, 2};
        vecs[13] = '{OP_LSR, 16'h0005, 16'd1,    1'b0, 1'b0, 16'h0002, 16'd14,   4'b0100, 2};
        vecs[14] = '{OP_LSL, 16'hF001, 16'd4,    1'b0, 1'b0, 16'h0010, 16'd14,   4'b0100, 2};
        vecs[15] = '{OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h00F0, 16'd14,   4'b0000, 2};
        vecs[16] = '{OP_OR,  16'hF000, 16'h000F, 1'b0, 1'b0, 16'hF00F, 16'd14,   4'b0010, 2};
        vecs[17] = '{OP_XOR, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 16'd14,   4'b0001, 2};
        vecs[18] = '{OP_NOT, 16'h00FF, 16'h1234, 1'b0, 1'b0, 16'hFF00, 16'd14,   4'b0010, 2};
        vecs[19] = '{OP_TST, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 16'hFF00, 16'd14,   4'b0001, 2};
        vecs[20] = '{OP_INC, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'd14,   4'b0101, 2};
        vecs[21] = '{OP_DEC, 16'h8000, 16'h5555, 1'b0, 1'b0, 16'h7FFF, 16'd14,   4'b1000, 2};
        vecs[22] = '{OP_NOP, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h7FFF, 16'd14,   4'b1000, 2};
        vecs[23] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0001, 16'hFFFE, 4'b1100, 18};
        vecs[24] = '{OP_MOD, 16'hFFFF, 16'h0010, 1'b0, 1'b0, 16'h000F, 16'h0FFF, 4'b0000, 18};
        vecs[25] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h0FFF, 4'b1101, 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ALU_ready), 32'd1);
        chk("rst_done", 32'(ALU_done), 32'd0);
        chk("rst_rez", 32'(rez), 32'd0);
        chk("rst_rez_hi", 32'(rez_hi), 32'd0);
        chk("rst_flags", 32'(ALU_flags), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset in the middle of a MUL discards it without a done pulse
        issue(OP_MUL, 16'h1234, 16'h0100, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("mul_busy", 32'(ALU_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_ready", 32'(ALU_ready), 32'd1);
        chk("midrst_rez", 32'(rez), 32'd0);
        chk("midrst_flags", 32'(ALU_flags), 32'd0);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            e = '{vecs[i].e_rez, vecs[i].e_hi, vecs[i].e_fl, vecs[i].lat, i};
            sb.push_back(e);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].st, vecs[i].ab);
            wait_done(0);
        end

        // Abort five cycles into a DIV: back to idle, no done, outputs untouched
        d0 = done_cnt;
        issue(OP_DIV, 16'd100, 16'd7, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready_next", 32'(ALU_ready), 32'd1);
        repeat (25) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_rez", 32'(rez), 32'h0000);
        chk("abort_rez_hi", 32'(rez_hi), 32'h0FFF);
        chk("abort_flags", 32'(ALU_flags), 32'b1101);
        $display("txn abort: rez=%h rez_hi=%h flags=%b", rez, rez_hi, ALU_flags);

        // move while busy is ignored; only the original MUL completes
        e = '{16'd15, 16'd0, 4'b0000, 18, 100};
        sb.push_back(e);
        issue(OP_MUL, 16'd3, 16'd5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        op_code = OP_ADD;
        reg0    = 16'd1;
        val     = 16'd1;
        move    = 1'b1;
        repeat (3) @(negedge clk);
        move = 1'b0;
        chk("busy_ready_low", 32'(ALU_ready), 32'd0);
        wait_done(5);
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("busy_move_not_queued", 32'(done_cnt), 32'(d0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
